adder_pipe_nbit: RTL and testbench

//  Parametrised pipelined N-bit adder. Successor to the fixed 8-bit combinational adder.

---
 rtl/adder_pkg.sv | 22 ++
 rtl/adder_seg.sv | 26 ++
 rtl/adder_pipe_nbit.sv | 151 +++++++++++++++
 tb/tb_adder_pipe_nbit.sv | 240 ++++++++++++++++++++++++
 4 files changed

// File: rtl/adder_pkg.sv
// Shared helpers for the adder family.
//   seg_lsb      : bit index of the least significant bit of carry segment k.
//   params_legal : elaboration-time legality of a WIDTH / STAGES pair.
package adder_pkg;

  // LSB position of segment k when every segment is seg bits wide.
  function automatic int seg_lsb(input int k, input int seg);
    return k * seg;
  endfunction

  // WIDTH must split evenly into at least one segment.
  function automatic bit params_legal(input int width, input int stages);
    bit ok;
    if (stages >= 1) begin
      ok = (width >= 1) && ((width % stages) == 0);
    end else begin
      ok = 1'b0;
    end
    return ok;
  endfunction

endpackage

// File: rtl/adder_seg.sv
// One carry segment of the pipelined adder: SEG-bit adder, purely combinational.
// Ports:
//   a, b       in  SEG  segment operands
//   carry_in   in  1    carry into the segment LSB
//   sum        out SEG  segment sum
//   carry_out  out 1    carry out of the segment MSB
//   carry_msb  out 1    carry into the segment MSB (overflow detection in the top segment)
module adder_seg #(
  parameter int SEG = 8
) (
  input  logic [SEG-1:0] a,
  input  logic [SEG-1:0] b,
  input  logic           carry_in,
  output logic [SEG-1:0] sum,
  output logic           carry_out,
  output logic           carry_msb
);

  // Segment addition with the carry extracted from the extra result bit.
  always_comb begin
    {carry_out, sum} = {1'b0, a} + {1'b0, b} + {{SEG{1'b0}}, carry_in};
    // sum[msb] = a ^ b ^ c_in(msb), so the carry into the MSB falls out directly.
    carry_msb = sum[SEG-1] ^ a[SEG-1] ^ b[SEG-1];
  end

endmodule

// File: rtl/adder_pipe_nbit.sv
// Pipelined WIDTH-bit adder with STAGES carry segments and a valid/ready stream.
// Stage k adds segment k of the operands to the carry registered by stage k-1;
// not-yet-added operand bits and finished sum bits ride along so the last stage
// holds a fully aligned result.
// Ports:
//   clk, rst_n            clock, asynchronous active-low reset
//   in_valid / in_ready   input handshake (in_ready = advance enable)
//   a, b, carry_in        operands
//   out_valid / out_ready output handshake
//   sum, carry_out        (a + b + carry_in) mod 2^WIDTH and its unsigned carry
//   overflow              two's-complement overflow
module adder_pipe_nbit
  import adder_pkg::*;
#(
  parameter int WIDTH  = 32,
  parameter int STAGES = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             carry_in,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] sum,
  output logic             carry_out,
  output logic             overflow
);

  // Guarded sizes so an illegal configuration reaches the fatal check below.
  localparam int DEPTH = (STAGES >= 1) ? STAGES : 1;
  localparam int SEG   = WIDTH / DEPTH;

  if (!params_legal(WIDTH, STAGES)) begin : g_param_check
    $fatal(1, "adder_pipe_nbit: WIDTH must be a positive multiple of STAGES, STAGES >= 1");
  end

  logic             valid_q [DEPTH];
  logic             valid_d [DEPTH];
  logic             carry_q [DEPTH];
  logic             carry_d [DEPTH];
  logic [WIDTH-1:0] sum_q   [DEPTH];
  logic [WIDTH-1:0] sum_d   [DEPTH];
  logic [WIDTH-1:0] a_q     [DEPTH];
  logic [WIDTH-1:0] a_d     [DEPTH];
  logic [WIDTH-1:0] b_q     [DEPTH];
  logic [WIDTH-1:0] b_d     [DEPTH];
  logic             ovf_q;
  logic             ovf_d;

  logic [SEG-1:0]   seg_sum_s  [DEPTH];
  logic             seg_cout_s [DEPTH];
  logic             seg_cmsb_s [DEPTH];
  logic             adv_s;
  logic             unused_ops_s;

  // The whole pipe moves when the head is empty or being drained.
  assign adv_s    = out_ready | ~valid_q[DEPTH-1];
  assign in_ready = adv_s;

  for (genvar k = 0; k < DEPTH; k++) begin : g_seg
    logic [SEG-1:0] op_a_s;
    logic [SEG-1:0] op_b_s;
    logic           cin_s;

    if (k == 0) begin : g_first
      assign op_a_s = a[0 +: SEG];
      assign op_b_s = b[0 +: SEG];
      assign cin_s  = carry_in;
    end else begin : g_rest
      assign op_a_s = a_q[k-1][seg_lsb(k, SEG) +: SEG];
      assign op_b_s = b_q[k-1][seg_lsb(k, SEG) +: SEG];
      assign cin_s  = carry_q[k-1];
    end

    adder_seg #(.SEG(SEG)) u_seg (
      .a         (op_a_s),
      .b         (op_b_s),
      .carry_in  (cin_s),
      .sum       (seg_sum_s[k]),
      .carry_out (seg_cout_s[k]),
      .carry_msb (seg_cmsb_s[k])
    );
  end

  // Next state: shift every stage by one on adv, otherwise hold everything.
  always_comb begin
    if (adv_s) begin
      valid_d[0]          = in_valid;
      a_d[0]              = a;
      b_d[0]              = b;
      sum_d[0]            = '0;
      sum_d[0][SEG-1:0]   = seg_sum_s[0];
      carry_d[0]          = seg_cout_s[0];
      for (int k = 1; k < DEPTH; k++) begin
        valid_d[k]                       = valid_q[k-1];
        a_d[k]                           = a_q[k-1];
        b_d[k]                           = b_q[k-1];
        sum_d[k]                         = sum_q[k-1];
        sum_d[k][seg_lsb(k, SEG) +: SEG] = seg_sum_s[k];
        carry_d[k]                       = seg_cout_s[k];
      end
      ovf_d = seg_cmsb_s[DEPTH-1] ^ seg_cout_s[DEPTH-1];
    end else begin
      valid_d = valid_q;
      a_d     = a_q;
      b_d     = b_q;
      sum_d   = sum_q;
      carry_d = carry_q;
      ovf_d   = ovf_q;
    end
  end

  // Pipeline registers; reset clears valids and data so nothing is ever X.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int k = 0; k < DEPTH; k++) begin
        valid_q[k] <= 1'b0;
        carry_q[k] <= 1'b0;
        sum_q[k]   <= '0;
        a_q[k]     <= '0;
        b_q[k]     <= '0;
      end
      ovf_q <= 1'b0;
    end else begin
      valid_q <= valid_d;
      carry_q <= carry_d;
      sum_q   <= sum_d;
      a_q     <= a_d;
      b_q     <= b_d;
      ovf_q   <= ovf_d;
    end
  end

  // Operand bits already consumed, and carry-into-MSB of non-final segments,
  // have no reader; fold them into one sink so their disuse is deliberate.
  always_comb begin
    unused_ops_s = 1'b0;
    for (int k = 0; k < DEPTH; k++) begin
      unused_ops_s = unused_ops_s ^ (^a_q[k]) ^ (^b_q[k]) ^ seg_cmsb_s[k];
    end
  end

  assign out_valid = valid_q[DEPTH-1];
  assign sum       = sum_q[DEPTH-1];
  assign carry_out = carry_q[DEPTH-1];
  assign overflow  = ovf_q;

endmodule

// File: tb/tb_adder_pipe_nbit.sv
// Bench for adder_pipe_nbit: an 8-bit/2-stage and a 32-bit/4-stage instance,
// directed corner cases with hand-derived results plus a random stream checked
// against plain-arithmetic reference functions through expectation queues.
module tb_adder_pipe_nbit;

  logic clk;
  logic rst_n;

  logic        in_valid8, in_ready8, cin8, out_valid8, out_ready8, carry_out8, overflow8;
  logic [7:0]  a8, b8, sum8;
  logic        in_valid32, in_ready32, cin32, out_valid32, out_ready32, carry_out32, overflow32;
  logic [31:0] a32, b32, sum32;

  adder_pipe_nbit #(.WIDTH(8), .STAGES(2)) u_dut8 (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid8), .in_ready(in_ready8),
    .a(a8), .b(b8), .carry_in(cin8), .out_valid(out_valid8), .out_ready(out_ready8),
    .sum(sum8), .carry_out(carry_out8), .overflow(overflow8)
  );

  adder_pipe_nbit #(.WIDTH(32), .STAGES(4)) u_dut32 (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid32), .in_ready(in_ready32),
    .a(a32), .b(b32), .carry_in(cin32), .out_valid(out_valid32), .out_ready(out_ready32),
    .sum(sum32), .carry_out(carry_out32), .overflow(overflow32)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_bad = 0;
  int cyc   = 0;

  // Expected results {overflow, carry_out, sum} and accept cycle, oldest first.
  logic [9:0]  exp8_q[$];
  int          acc8_q[$];
  logic [33:0] exp32_q[$];
  int          acc32_q[$];
  logic [9:0]  cur_exp8;
  logic [33:0] cur_exp32;
  logic        acc8, acc32;
  logic        lat_chk8, lat_chk32;

  task automatic check_val(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", tag, obs, exp, cyc);
    end
  endtask

  // Reference: plain unsigned sum, overflow from the sign rule.
  function automatic logic [9:0] ref8(input logic [7:0] x, input logic [7:0] y, input logic c);
    logic [8:0] full;
    full = {1'b0, x} + {1'b0, y} + {8'd0, c};
    return {(x[7] == y[7]) && (full[7] != x[7]), full[8], full[7:0]};
  endfunction

  function automatic logic [33:0] ref32(input logic [31:0] x, input logic [31:0] y, input logic c);
    logic [32:0] full;
    full = {1'b0, x} + {1'b0, y} + {32'd0, c};
    return {(x[31] == y[31]) && (full[31] != x[31]), full[32], full[31:0]};
  endfunction

  // One clock: sample handshakes between edges, update scoreboards, advance.
  task automatic tick();
    logic [9:0]  e8;
    logic [33:0] e32;
    int          ac;
    #1;
    if (out_valid8 && out_ready8) begin
      if (exp8_q.size() == 0) begin
        check_val("dut8_spurious_out", 64'(out_valid8), 64'd0);
      end else begin
        e8 = exp8_q.pop_front();
        ac = acc8_q.pop_front();
        check_val("dut8_sum", 64'(sum8), 64'(e8[7:0]));
        check_val("dut8_carry_out", 64'(carry_out8), 64'(e8[8]));
        check_val("dut8_overflow", 64'(overflow8), 64'(e8[9]));
        if (lat_chk8) check_val("dut8_latency", 64'(cyc - ac), 64'd2);
      end
    end
    acc8 = in_valid8 && in_ready8;
    if (acc8) begin
      exp8_q.push_back(cur_exp8);
      acc8_q.push_back(cyc);
    end
    if (out_valid32 && out_ready32) begin
      if (exp32_q.size() == 0) begin
        check_val("dut32_spurious_out", 64'(out_valid32), 64'd0);
      end else begin
        e32 = exp32_q.pop_front();
        ac  = acc32_q.pop_front();
        check_val("dut32_sum", 64'(sum32), 64'(e32[31:0]));
        check_val("dut32_carry_out", 64'(carry_out32), 64'(e32[32]));
        check_val("dut32_overflow", 64'(overflow32), 64'(e32[33]));
        if (lat_chk32) check_val("dut32_latency", 64'(cyc - ac), 64'd4);
      end
    end
    acc32 = in_valid32 && in_ready32;
    if (acc32) begin
      exp32_q.push_back(cur_exp32);
      acc32_q.push_back(cyc);
    end
    @(posedge clk);
    cyc++;
    @(negedge clk);
    #1;
  endtask

  task automatic set8(input logic [7:0] x, input logic [7:0] y, input logic c, input logic [9:0] e);
    a8 = x; b8 = y; cin8 = c; cur_exp8 = e; in_valid8 = 1'b1;
  endtask

  // Present an op and hold it until accepted; in_valid8 stays high afterwards.
  task automatic send8(input logic [7:0] x, input logic [7:0] y, input logic c, input logic [9:0] e);
    int n;
    set8(x, y, c, e);
    n = 0;
    do begin
      tick();
      n++;
    end while (!acc8 && n < 20);
    if (!acc8) check_val("dut8_accept_timeout", 64'(acc8), 64'd1);
  endtask

  task automatic send32(input logic [31:0] x, input logic [31:0] y, input logic c, input logic [33:0] e);
    int n;
    a32 = x; b32 = y; cin32 = c; cur_exp32 = e; in_valid32 = 1'b1;
    n = 0;
    do begin
      tick();
      n++;
    end while (!acc32 && n < 20);
    if (!acc32) check_val("dut32_accept_timeout", 64'(acc32), 64'd1);
  endtask

  task automatic drain(input int n);
    in_valid8 = 1'b0; in_valid32 = 1'b0;
    out_ready8 = 1'b1; out_ready32 = 1'b1;
    repeat (n) tick();
    check_val("dut8_queue_empty", 64'(exp8_q.size()), 64'd0);
    check_val("dut32_queue_empty", 64'(exp32_q.size()), 64'd0);
  endtask

  initial begin
    int n32;
    int n8;
    int budget;
    rst_n = 1'b1;
    in_valid8 = 1'b0; a8 = 8'd0; b8 = 8'd0; cin8 = 1'b0; out_ready8 = 1'b1;
    in_valid32 = 1'b0; a32 = 32'd0; b32 = 32'd0; cin32 = 1'b0; out_ready32 = 1'b1;
    cur_exp8 = 10'd0; cur_exp32 = 34'd0; acc8 = 1'b0; acc32 = 1'b0;
    lat_chk8 = 1'b1; lat_chk32 = 1'b1;
    #2 rst_n = 1'b0;
    repeat (2) @(negedge clk);
    #1;
    check_val("rst_out_valid8", 64'(out_valid8), 64'd0);
    check_val("rst_sum8", 64'(sum8), 64'd0);
    check_val("rst_carry8", 64'(carry_out8), 64'd0);
    check_val("rst_ovf8", 64'(overflow8), 64'd0);
    check_val("rst_out_valid32", 64'(out_valid32), 64'd0);
    check_val("rst_sum32", 64'(sum32), 64'd0);
    rst_n = 1'b1;

    // 1) zero, 2) carry across the segment boundary, 3) overflow cases.
    send8(8'h00, 8'h00, 1'b0, {1'b0, 1'b0, 8'h00});
    send8(8'hFF, 8'h01, 1'b0, {1'b0, 1'b1, 8'h00});
    send8(8'h7F, 8'h7F, 1'b1, {1'b1, 1'b0, 8'hFF});
    send8(8'h80, 8'h80, 1'b0, {1'b1, 1'b1, 8'h00});
    drain(4);

    // 4) back-to-back stream with the consumer stalled for 3 cycles.
    lat_chk8 = 1'b0;
    send8(8'hC8, 8'h37, 1'b1, {1'b0, 1'b1, 8'h00});
    send8(8'h00, 8'hFF, 1'b1, {1'b0, 1'b1, 8'h00});
    set8(8'h80, 8'h80, 1'b0, {1'b1, 1'b1, 8'h00});
    out_ready8 = 1'b0;
    repeat (3) begin
      tick();
      check_val("stall_accept8", 64'(acc8), 64'd0);
      check_val("stall_in_ready8", 64'(in_ready8), 64'd0);
      check_val("stall_out_valid8", 64'(out_valid8), 64'd1);
    end
    out_ready8 = 1'b1;
    send8(8'h80, 8'h80, 1'b0, {1'b1, 1'b1, 8'h00});
    drain(5);
    lat_chk8 = 1'b1;

    // 5) reset with two ops in flight, then normal latency afterwards.
    send8(8'h12, 8'h34, 1'b0, {1'b0, 1'b0, 8'h46});
    send8(8'h56, 8'h78, 1'b0, {1'b1, 1'b0, 8'hCE});
    in_valid8 = 1'b0;
    rst_n = 1'b0;
    #1;
    check_val("midrst_out_valid8", 64'(out_valid8), 64'd0);
    check_val("midrst_sum8", 64'(sum8), 64'd0);
    exp8_q.delete(); acc8_q.delete(); exp32_q.delete(); acc32_q.delete();
    @(negedge clk);
    #1;
    rst_n = 1'b1;
    send8(8'h01, 8'h01, 1'b0, {1'b0, 1'b0, 8'h02});
    drain(4);

    // 6) 32-bit all-ones + carry-in ripples through all four segments.
    send32(32'hFFFF_FFFF, 32'h0000_0000, 1'b1, {1'b0, 1'b1, 32'h0000_0000});
    drain(6);

    // Random streams with random back-pressure on both instances.
    lat_chk8 = 1'b0; lat_chk32 = 1'b0;
    n32 = 0; n8 = 0; budget = 0;
    while (n32 < 1000 && budget < 20000) begin
      if (!in_valid32 || acc32) begin
        in_valid32 = ($urandom_range(3, 0) != 0);
        a32 = ($urandom_range(7, 0) == 0) ? 32'hFFFF_FFFF : 32'($urandom);
        b32 = ($urandom_range(7, 0) == 0) ? 32'h8000_0000 : 32'($urandom);
        cin32 = 1'($urandom_range(1, 0));
        cur_exp32 = ref32(a32, b32, cin32);
      end
      if (!in_valid8 || acc8) begin
        in_valid8 = ($urandom_range(3, 0) != 0);
        a8 = 8'($urandom);
        b8 = 8'($urandom);
        cin8 = 1'($urandom_range(1, 0));
        cur_exp8 = ref8(a8, b8, cin8);
      end
      out_ready32 = ($urandom_range(3, 0) != 0);
      out_ready8  = ($urandom_range(3, 0) != 0);
      tick();
      if (acc32) n32++;
      if (acc8) n8++;
      budget++;
    end
    if (n32 < 1000) check_val("random_budget_expired", 64'(n32), 64'd1000);
    drain(10);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
